// File: rtl/rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter_if
//  Description : Request/grant bundle between a set of requesters and the
//                round-robin arbiter that shares one resource among them.
//
//                requests     requester -> arbiter, bit i = requester i
//                grants       arbiter -> resource, one-hot or zero
//                grant_valid  arbiter -> resource, high when any grant set
//                grant_id     arbiter -> resource, index of current owner
//
//                master modport : requester side (drives requests)
//                slave modport  : arbiter side (drives grants)
//  Revision    : 1.0  initial release
// ============================================================================
interface rr_arbiter_if #(
    parameter int NUM_REQ = 3
);

    localparam int c_IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] requests;
    logic [NUM_REQ-1:0] grants;
    logic               grant_valid;
    logic [c_IDW-1:0]   grant_id;

    modport master (
        output requests,
        input  grants,
        input  grant_valid,
        input  grant_id
    );

    modport slave (
        input  requests,
        output grants,
        output grant_valid,
        output grant_id
    );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Registered round-robin arbiter sharing one resource among
//                NUM_REQ requesters. The owner keeps the grant while it keeps
//                requesting, but is forcibly rotated out after MAX_HOLD
//                consecutive cycles if anyone else is waiting. A release
//                hands the grant to the next requester on the same edge.
//
//  Ports       : clk    rising-edge clock
//                reset  asynchronous active-high reset
//                arb    rr_arbiter_if.slave
//                         requests    in   request vector
//                         grants      out  registered one-hot grant / zero
//                         grant_valid out  registered, |grants
//                         grant_id    out  registered owner index, 0 if idle
//  Parameters  : NUM_REQ   number of requesters, 2..16
//                MAX_HOLD  max consecutive grant cycles while others wait, >=1
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int MAX_HOLD = 4
) (
    input  wire          clk,
    input  wire          reset,
    rr_arbiter_if.slave  arb
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    localparam logic [c_HCW-1:0]   c_HCNT_MAX = c_HCW'(MAX_HOLD - 1);
    localparam logic [c_IDW-1:0]   c_LAST_IDX = c_IDW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] c_ONE      = NUM_REQ'(1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]         r_state;
    logic [c_IDW-1:0]   r_ptr;
    logic [c_HCW-1:0]   r_hcnt;
    logic [NUM_REQ-1:0] r_grants;
    logic               r_grant_valid;
    logic [c_IDW-1:0]   r_grant_id;

    logic [0:0]         w_state_nxt;
    logic [c_IDW-1:0]   w_ptr_nxt;
    logic [c_HCW-1:0]   w_hcnt_nxt;
    logic [NUM_REQ-1:0] w_grants_nxt;
    logic               w_grant_valid_nxt;
    logic [c_IDW-1:0]   w_grant_id_nxt;

    logic               w_found;
    logic [c_IDW-1:0]   w_found_idx;
    logic               w_owner_req;
    logic               w_others_req;
    logic               w_take;

    // ------------------------------------------------------------------------
    // Round-robin search starting at r_ptr.
    // While BUSY with owner k, r_ptr already holds (k+1) mod NUM_REQ, so the
    // same search serves both the idle grant and the release/preempt handoff;
    // the owner is naturally the last candidate visited.
    // The loop runs from the farthest offset down to zero so that the
    // nearest requesting index is the final (winning) assignment.
    // ------------------------------------------------------------------------
    always_comb begin
        w_found     = 1'b0;
        w_found_idx = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            int idx;
            idx = int'(r_ptr) + j;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (arb.requests[idx]) begin
                w_found     = 1'b1;
                w_found_idx = c_IDW'(idx);
            end
        end
    end

    // r_grants is one-hot on the owner while BUSY, so masking with it
    // separates the owner's request from everyone else's.
    assign w_owner_req  = |(arb.requests & r_grants);
    assign w_others_req = |(arb.requests & ~r_grants);

    // ------------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_ptr_nxt         = r_ptr;
        w_hcnt_nxt        = r_hcnt;
        w_grants_nxt      = r_grants;
        w_grant_valid_nxt = r_grant_valid;
        w_grant_id_nxt    = r_grant_id;
        w_take            = 1'b0;

        case (r_state)
            c_IDLE: begin
                w_take = w_found;
            end

            c_BUSY: begin
                if (!w_owner_req) begin
                    // Release: hand off with no bubble if anyone is waiting,
                    // otherwise drop to idle. r_ptr already points past the
                    // old owner and is kept.
                    if (w_found) begin
                        w_take = 1'b1;
                    end else begin
                        w_state_nxt       = c_IDLE;
                        w_hcnt_nxt        = '0;
                        w_grants_nxt      = '0;
                        w_grant_valid_nxt = 1'b0;
                        w_grant_id_nxt    = '0;
                    end
                end else if ((r_hcnt == c_HCNT_MAX) && w_others_req) begin
                    // Preempt: hold budget spent and someone else waits.
                    w_take = 1'b1;
                end else if (r_hcnt != c_HCNT_MAX) begin
                    // Hold; the counter saturates so a lone owner keeps it.
                    w_hcnt_nxt = r_hcnt + c_HCW'(1);
                end
            end

            default: begin
                w_state_nxt       = c_IDLE;
                w_ptr_nxt         = '0;
                w_hcnt_nxt        = '0;
                w_grants_nxt      = '0;
                w_grant_valid_nxt = 1'b0;
                w_grant_id_nxt    = '0;
            end
        endcase

        if (w_take) begin
            w_state_nxt       = c_BUSY;
            w_ptr_nxt         = (w_found_idx == c_LAST_IDX) ? '0
                                                            : w_found_idx + c_IDW'(1);
            w_hcnt_nxt        = '0;
            w_grants_nxt      = c_ONE << w_found_idx;
            w_grant_valid_nxt = 1'b1;
            w_grant_id_nxt    = w_found_idx;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= c_IDLE;
            r_ptr         <= '0;
            r_hcnt        <= '0;
            r_grants      <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_hcnt        <= w_hcnt_nxt;
            r_grants      <= w_grants_nxt;
            r_grant_valid <= w_grant_valid_nxt;
            r_grant_id    <= w_grant_id_nxt;
        end
    end

    assign arb.grants      = r_grants;
    assign arb.grant_valid = r_grant_valid;
    assign arb.grant_id    = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arbiter
//  Description : Self-checking bench for rr_arbiter (NUM_REQ=3, MAX_HOLD=4).
//                A behavioural model computes the expected registered outputs
//                when requests are driven; the expectation is queued and
//                compared after the following rising edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rr_arbiter;

    localparam int NUM_REQ  = 3;
    localparam int MAX_HOLD = 4;

    typedef struct {
        logic [2:0] g;
        logic       v;
        logic [1:0] id;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    rr_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .arb   (bus)
    );

    int   n_vec = 0;
    int   n_err = 0;
    exp_t q[$];

    // model state
    logic m_busy;
    int   m_k;
    int   m_hcnt;
    int   m_ptr;

    int   wait_cnt[3];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int m_search(input logic [2:0] r, input int s);
        for (int j = 0; j < NUM_REQ; j++) begin
            if (r[(s + j) % NUM_REQ]) return (s + j) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic m_reset();
        m_busy = 1'b0; m_k = 0; m_hcnt = 0; m_ptr = 0;
        q.delete();
        for (int i = 0; i < 3; i++) wait_cnt[i] = 0;
    endtask

    task automatic m_grant(input int n);
        m_busy = 1'b1; m_k = n; m_hcnt = 0; m_ptr = (n + 1) % NUM_REQ;
    endtask

    task automatic m_step(input logic [2:0] r);
        int n;
        if (!m_busy) begin
            n = m_search(r, m_ptr);
            if (n >= 0) m_grant(n);
        end else if (!r[m_k]) begin
            n = m_search(r, (m_k + 1) % NUM_REQ);
            if (n >= 0) m_grant(n);
            else m_busy = 1'b0;
        end else if (m_hcnt == MAX_HOLD - 1 && (r & ~(3'b001 << m_k)) != 3'b000) begin
            m_grant(m_search(r, (m_k + 1) % NUM_REQ));
        end else if (m_hcnt < MAX_HOLD - 1) begin
            m_hcnt++;
        end
    endtask

    // Drive one request vector, compare after the edge; returns observed grants.
    task automatic step(input logic [2:0] r, output logic [2:0] g_obs);
        exp_t e;
        @(negedge clk);
        bus.requests = r;
        m_step(r);
        e.g  = m_busy ? (3'b001 << m_k) : 3'b000;
        e.v  = m_busy;
        e.id = m_busy ? 2'(m_k) : 2'd0;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("grants", 32'(bus.grants), 32'(e.g));
        check("valid", 32'(bus.grant_valid), 32'(e.v));
        check("id", 32'(bus.grant_id), 32'(e.id));
        check("onehot0", 32'($onehot0(bus.grants)), 32'd1);
        check("v_eq_or", 32'(bus.grant_valid), 32'(|bus.grants));
        if (bus.grant_valid)
            check("id_match", 32'(bus.grants[bus.grant_id]), 32'd1);
        for (int i = 0; i < 3; i++) begin
            if (r[i] && !bus.grants[i]) wait_cnt[i]++;
            else wait_cnt[i] = 0;
            if (r[i]) check("fair_bound", 32'(wait_cnt[i] < 9), 32'd1);
        end
        g_obs = bus.grants;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.requests = 3'b000;
        reset = 1'b1;
        #1;
        check("rst_g", 32'(bus.grants), 32'd0);
        check("rst_v", 32'(bus.grant_valid), 32'd0);
        check("rst_id", 32'(bus.grant_id), 32'd0);
        m_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_g", 32'(bus.grants), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] g;
        logic [2:0] seq2 [13];
        logic [2:0] r;

        reset        = 1'b1;
        bus.requests = 3'b000;
        m_reset();

        // 1. reset and a single lone requester held indefinitely
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(3'b001, g);
            check("t1_hold", 32'(g), 32'b001);
        end

        // 2. everyone requesting: rotation every MAX_HOLD cycles
        for (int i = 0; i < 13; i++)
            seq2[i] = (i < 4) ? 3'b001 : (i < 8) ? 3'b010 : (i < 12) ? 3'b100 : 3'b001;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            step(3'b111, g);
            check("t2_rot", 32'(g), 32'(seq2[i]));
        end

        // 3. release handoff from owner 1 skips to 2, no idle cycle
        do_reset();
        step(3'b010, g);
        check("t3_own1", 32'(g), 32'b010);
        step(3'b101, g);
        check("t3_hand", 32'(g), 32'b100);

        // 4. idle then wrap from ptr=2 to requester 0
        do_reset();
        step(3'b010, g);
        step(3'b000, g);
        check("t4_idle", 32'(g), 32'b000);
        step(3'b011, g);
        check("t4_wrap", 32'(g), 32'b001);

        // 5. asynchronous reset between edges while owner 1 holds
        do_reset();
        for (int i = 0; i < 5; i++) step(3'b111, g);
        check("t5_own1", 32'(g), 32'b010);
        #2;
        reset = 1'b1;
        #1;
        check("t5_async_g", 32'(bus.grants), 32'd0);
        check("t5_async_v", 32'(bus.grant_valid), 32'd0);
        #1;
        reset = 1'b0;
        m_reset();
        step(3'b111, g);
        check("t5_restart", 32'(g), 32'b001);

        // 6. random stress with sticky requests so holds and preempts occur
        do_reset();
        r = 3'b000;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) r = 3'($urandom_range(0, 7));
            step(r, g);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
